tl_refill_responder: RTL and testbench

TL_REFILL_RESPONDER -- requirements
Module: tl_refill_responder

---
 rtl/tl_refill_responder.sv | 155 +++++++++++++++
 tb/tb_tl_refill_responder.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_refill_responder.sv
// TileLink-style refill responder: accepts one A request at a time, waits a fixed
// latency, then streams the D response beats for it.
module tl_refill_responder #(
   parameter int unsigned LATENCY = 2,
   parameter logic [31:0] BASE    = 32'h8000_0000,
   parameter int unsigned SIZE_LG = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        auto_in_a_valid,
   output logic        auto_in_a_ready,
   input  logic [2:0]  auto_in_a_bits_opcode,
   input  logic [2:0]  auto_in_a_bits_param,
   input  logic [3:0]  auto_in_a_bits_size,
   input  logic        auto_in_a_bits_source,
   input  logic [31:0] auto_in_a_bits_address,
   input  logic [7:0]  auto_in_a_bits_mask,
   output logic        auto_in_d_valid,
   input  logic        auto_in_d_ready,
   output logic [2:0]  auto_in_d_bits_opcode,
   output logic [1:0]  auto_in_d_bits_param,
   output logic [3:0]  auto_in_d_bits_size,
   output logic        auto_in_d_bits_source,
   output logic [2:0]  auto_in_d_bits_sink,
   output logic [63:0] auto_in_d_bits_data,
   output logic        auto_in_d_bits_error,
   output logic [15:0] io_resp_count
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

   localparam logic [3:0]  LAT_M1     = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
   localparam logic [32:0] REGION_END = {1'b0, BASE} + (33'd1 << SIZE_LG);

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [2:0]  beat_q;
   logic [2:0]  last_q;
   logic [2:0]  d_opcode_q;
   logic [3:0]  size_q;
   logic        source_q;
   logic [31:0] base_q;
   logic        err_q;
   logic        a_ready_q;
   logic        d_valid_q;
   logic [15:0] resp_count_q;

   logic        in_region;
   logic        get_ok;
   logic [2:0]  last_d;
   logic [31:0] aligned_d;
   logic [31:0] beat_addr;
   logic        unused_a_fields;

   assign unused_a_fields = ^{auto_in_a_bits_param, auto_in_a_bits_mask};

   // Decode of the incoming request, only consumed on the accepting edge.
   always_comb begin
      in_region = ({1'b0, auto_in_a_bits_address} >= {1'b0, BASE}) &&
                  ({1'b0, auto_in_a_bits_address} < REGION_END);
      get_ok    = (auto_in_a_bits_opcode == 3'd4) && in_region &&
                  (auto_in_a_bits_size <= 4'd6);
      aligned_d = auto_in_a_bits_address &
                  ~((32'd1 << auto_in_a_bits_size) - 32'd1);
      last_d    = 3'd0;
      if (get_ok) begin
         case (auto_in_a_bits_size)
            4'd4:    last_d = 3'd1;
            4'd5:    last_d = 3'd3;
            4'd6:    last_d = 3'd7;
            default: last_d = 3'd0;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         beat_q       <= 3'd0;
         last_q       <= 3'd0;
         d_opcode_q   <= 3'd0;
         size_q       <= 4'd0;
         source_q     <= 1'b0;
         base_q       <= 32'd0;
         err_q        <= 1'b0;
         a_ready_q    <= 1'b0;
         d_valid_q    <= 1'b0;
         resp_count_q <= 16'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               a_ready_q <= 1'b1;
               if (auto_in_a_valid && a_ready_q) begin
                  a_ready_q  <= 1'b0;
                  d_opcode_q <= (auto_in_a_bits_opcode == 3'd4) ? 3'd1 : 3'd0;
                  size_q     <= auto_in_a_bits_size;
                  source_q   <= auto_in_a_bits_source;
                  base_q     <= get_ok ? aligned_d : 32'd0;
                  err_q      <= ~get_ok;
                  last_q     <= last_d;
                  beat_q     <= 3'd0;
                  if (LATENCY == 0) begin
                     state_q   <= S_BURST;
                     d_valid_q <= 1'b1;
                  end else begin
                     state_q <= S_WAIT;
                     cnt_q   <= LAT_M1;
                  end
               end
            end
            S_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q   <= S_BURST;
                  d_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_BURST: begin
               if (auto_in_d_ready) begin
                  if (beat_q == last_q) begin
                     state_q      <= S_IDLE;
                     d_valid_q    <= 1'b0;
                     a_ready_q    <= 1'b1;
                     beat_q       <= 3'd0;
                     resp_count_q <= resp_count_q + 16'd1;
                  end else begin
                     beat_q <= beat_q + 3'd1;
                  end
               end
            end
            default: begin
               state_q   <= S_IDLE;
               d_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Error responses carry base_q = 0 and are forced to zero data anyway.
   assign beat_addr = base_q + {26'd0, beat_q, 3'd0};

   assign auto_in_a_ready       = a_ready_q;
   assign auto_in_d_valid       = d_valid_q;
   assign auto_in_d_bits_opcode = d_valid_q ? d_opcode_q : 3'd0;
   assign auto_in_d_bits_param  = 2'd0;
   assign auto_in_d_bits_size   = d_valid_q ? size_q : 4'd0;
   assign auto_in_d_bits_source = d_valid_q & source_q;
   assign auto_in_d_bits_sink   = 3'd0;
   assign auto_in_d_bits_error  = d_valid_q & err_q;
   assign auto_in_d_bits_data   = (d_valid_q && !err_q) ? {beat_addr, ~beat_addr} : 64'd0;
   assign io_resp_count         = resp_count_q;

endmodule

// File: tb/tb_tl_refill_responder.sv
// Scoreboard bench: the driver pushes model-predicted D beats, a negedge monitor
// pops and compares them; a second LATENCY=0 instance covers back-to-back accepts.
module tb_tl_refill_responder;

   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam int LATENCY = 2;

   typedef struct {
      logic [2:0]  op;
      logic [3:0]  size;
      logic        src;
      logic        err;
      logic [63:0] data;
   } beat_t;

   logic clk, rst_n;
   logic a_valid, a_ready, a_source, d_valid, d_ready, d_source, d_error;
   logic [2:0] a_opcode, a_param, d_opcode, d_sink;
   logic [3:0] a_size, d_size;
   logic [31:0] a_address;
   logic [7:0] a_mask;
   logic [1:0] d_param;
   logic [63:0] d_data;
   logic [15:0] count;

   logic z_a_valid, z_a_ready, z_d_valid, z_d_ready, z_d_source, z_d_error;
   logic [2:0] z_d_opcode, z_d_sink;
   logic [1:0] z_d_param;
   logic [3:0] z_d_size;
   logic [63:0] z_d_data;
   logic [15:0] z_count;

   int errors = 0;
   int checks = 0;
   beat_t sb[$];
   logic [15:0] exp_resp = 16'd0;
   bit tog_mode = 0, tog_sync = 0, rnd_mode = 0;

   logic [1:0] z_exp_vr [6] = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
   int         z_exp_cnt[6] = '{0, 0, 1, 1, 1, 2};

   tl_refill_responder #(.LATENCY(LATENCY)) u_dut (
      .clock(clk), .reset(rst_n),
      .auto_in_a_valid(a_valid), .auto_in_a_ready(a_ready),
      .auto_in_a_bits_opcode(a_opcode), .auto_in_a_bits_param(a_param),
      .auto_in_a_bits_size(a_size), .auto_in_a_bits_source(a_source),
      .auto_in_a_bits_address(a_address), .auto_in_a_bits_mask(a_mask),
      .auto_in_d_valid(d_valid), .auto_in_d_ready(d_ready),
      .auto_in_d_bits_opcode(d_opcode), .auto_in_d_bits_param(d_param),
      .auto_in_d_bits_size(d_size), .auto_in_d_bits_source(d_source),
      .auto_in_d_bits_sink(d_sink), .auto_in_d_bits_data(d_data),
      .auto_in_d_bits_error(d_error), .io_resp_count(count)
   );

   tl_refill_responder #(.LATENCY(0)) u_dut0 (
      .clock(clk), .reset(rst_n),
      .auto_in_a_valid(z_a_valid), .auto_in_a_ready(z_a_ready),
      .auto_in_a_bits_opcode(3'd4), .auto_in_a_bits_param(3'd0),
      .auto_in_a_bits_size(4'd4), .auto_in_a_bits_source(1'b1),
      .auto_in_a_bits_address(32'h8000_0100), .auto_in_a_bits_mask(8'hFF),
      .auto_in_d_valid(z_d_valid), .auto_in_d_ready(z_d_ready),
      .auto_in_d_bits_opcode(z_d_opcode), .auto_in_d_bits_param(z_d_param),
      .auto_in_d_bits_size(z_d_size), .auto_in_d_bits_source(z_d_source),
      .auto_in_d_bits_sink(z_d_sink), .auto_in_d_bits_data(z_d_data),
      .auto_in_d_bits_error(z_d_error), .io_resp_count(z_count)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // Reference model: region test, beat count and beat addresses in plain arithmetic.
   function automatic int push_model(input logic [2:0] op, input logic [3:0] sz,
                                     input logic src, input logic [31:0] addr);
      longint unsigned a, lo, hi, blk, aligned;
      logic [31:0] ab;
      int n;
      beat_t e;
      a  = addr;
      lo = BASE;
      hi = lo + 64'd65536;
      e.size = sz;
      e.src  = src;
      if (op == 3'd4 && sz <= 4'd6 && a >= lo && a < hi) begin
         blk     = 64'd1 << sz;
         aligned = a - (a % blk);
         n       = (blk < 8) ? 1 : int'(blk / 8);
         for (int b = 0; b < n; b++) begin
            ab     = 32'(aligned + longint'(8 * b));
            e.op   = 3'd1;
            e.err  = 1'b0;
            e.data = {ab, ~ab};
            sb.push_back(e);
         end
      end else begin
         n      = 1;
         e.op   = (op == 3'd4) ? 3'd1 : 3'd0;
         e.err  = 1'b1;
         e.data = 64'd0;
         sb.push_back(e);
      end
      return n;
   endfunction

   initial begin
      d_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (tog_mode) begin
            if (tog_sync) begin
               d_ready  = 1'b1;
               tog_sync = 0;
            end else begin
               d_ready = ~d_ready;
            end
         end else begin
            d_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end
   end

   // Monitor: every presented beat (stalled or not) must equal the queue head.
   always @(negedge clk) begin
      if (rst_n && d_valid) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL d_unexpected: beat data=%h presented, required no beat", d_data);
         end else begin
            if (d_opcode !== sb[0].op || d_size !== sb[0].size || d_source !== sb[0].src ||
                d_error !== sb[0].err || d_data !== sb[0].data || d_param !== 2'd0 ||
                d_sink !== 3'd0 || a_ready !== 1'b0) begin
               errors++;
               $display("FAIL d_beat: got op=%0d size=%0d src=%0b err=%0b data=%h param=%0d sink=%0d a_ready=%0b, required op=%0d size=%0d src=%0b err=%0b data=%h param=0 sink=0 a_ready=0",
                        d_opcode, d_size, d_source, d_error, d_data, d_param, d_sink, a_ready,
                        sb[0].op, sb[0].size, sb[0].src, sb[0].err, sb[0].data);
            end
            if (d_ready) void'(sb.pop_front());
         end
      end
   end

   task automatic run_txn(input logic [2:0] op, input logic [3:0] sz, input logic src,
                          input logic [31:0] addr, input bit tog, input int exp_burst);
      int guard, lat, burst;
      @(negedge clk);
      guard = 0;
      while (!a_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (a_ready !== 1'b1) begin
         errors++;
         $display("FAIL a_ready_wait: a_ready=%0b, required 1", a_ready);
      end
      a_valid   = 1'b1;
      a_opcode  = op;
      a_size    = sz;
      a_source  = src;
      a_address = addr;
      void'(push_model(op, sz, src, addr));
      tog_mode = tog;
      if (tog) tog_sync = 1;
      @(posedge clk);
      #1;
      // Junk on A while busy must be ignored.
      a_valid   = 1'($urandom_range(0, 1));
      a_opcode  = 3'($urandom);
      a_size    = 4'($urandom);
      a_source  = 1'($urandom);
      a_address = $urandom;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!d_valid && lat < 40);
      a_valid = 1'b0;
      checks++;
      if (lat != LATENCY + 1) begin
         errors++;
         $display("FAIL latency: first d_valid %0d cycles after accept, required %0d", lat, LATENCY + 1);
      end
      burst = 0;
      while (d_valid && burst < 400) begin
         burst++;
         @(negedge clk);
      end
      exp_resp = exp_resp + 16'd1;
      if (exp_burst > 0) begin
         checks++;
         if (burst != exp_burst) begin
            errors++;
            $display("FAIL burst_cycles: got %0d, required %0d", burst, exp_burst);
         end
      end
      checks++;
      if (sb.size() != 0 || a_ready !== 1'b1 || count !== exp_resp) begin
         errors++;
         $display("FAIL complete: pending=%0d a_ready=%0b count=%0d, required pending=0 a_ready=1 count=%0d",
                  sb.size(), a_ready, count, exp_resp);
      end
      tog_mode = 0;
   endtask

   initial begin
      logic [2:0]  op;
      logic [3:0]  sz;
      logic [31:0] addr;
      int r, guard;
      rst_n = 0;
      a_valid = 0; a_opcode = 0; a_param = 0; a_size = 0; a_source = 0;
      a_address = 0; a_mask = 8'hFF;
      z_a_valid = 1; z_d_ready = 1;
      #2;
      checks++;
      if (a_ready !== 1'b0 || d_valid !== 1'b0 || count !== 16'd0 || d_data !== 64'd0 ||
          d_error !== 1'b0 || z_a_ready !== 1'b0 || z_d_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: a_ready=%0b d_valid=%0b count=%0d data=%h err=%0b z_a_ready=%0b z_d_valid=%0b, required all 0",
                  a_ready, d_valid, count, d_data, d_error, z_a_ready, z_d_valid);
      end
      #20 rst_n = 1;
      @(negedge clk);
      checks++;
      if (a_ready !== 1'b1 || z_a_ready !== 1'b1) begin
         errors++;
         $display("FAIL a_ready_after_reset: a_ready=%0b z_a_ready=%0b, required 1 1", a_ready, z_a_ready);
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 5) z_a_valid = 0;
         checks++;
         if ({z_d_valid, z_a_ready} !== z_exp_vr[k] || z_count !== 16'(z_exp_cnt[k])) begin
            errors++;
            $display("FAIL lat0_b2b[%0d]: d_valid,a_ready=%b count=%0d, required %b count=%0d",
                     k, {z_d_valid, z_a_ready}, z_count, z_exp_vr[k], z_exp_cnt[k]);
         end
      end

      rnd_mode = 0;
      run_txn(3'd4, 4'd6, 1'b0, 32'h8000_0040, 0, 8);
      run_txn(3'd4, 4'd6, 1'b1, 32'h8000_0040, 1, 15);
      run_txn(3'd4, 4'd6, 1'b0, 32'h0000_1000, 0, 1);
      run_txn(3'd0, 4'd3, 1'b1, 32'h8000_0100, 0, 1);
      run_txn(3'd4, 4'd2, 1'b1, 32'h8000_FFFF, 0, 1);
      run_txn(3'd4, 4'd7, 1'b0, 32'h8000_0000, 0, 1);

      for (int t = 0; t < 40; t++) begin
         op = ($urandom_range(0, 9) < 7) ? 3'd4 : 3'($urandom_range(0, 7));
         sz = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
         r  = $urandom_range(0, 9);
         if (r < 6)       addr = BASE + 32'($urandom_range(0, 65535));
         else if (r == 6) addr = BASE + 32'd65536 - 32'($urandom_range(1, 64));
         else if (r == 7) addr = BASE + 32'd65536 + 32'($urandom_range(0, 63));
         else if (r == 8) addr = BASE - 32'($urandom_range(1, 64));
         else             addr = $urandom;
         rnd_mode = 1'($urandom_range(0, 1));
         run_txn(op, sz, 1'($urandom), addr, 0, 0);
      end

      // Reset during the third beat of an 8-beat burst.
      rnd_mode = 0;
      @(negedge clk);
      guard = 0;
      while (!a_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      a_valid = 1; a_opcode = 3'd4; a_size = 4'd6; a_source = 0; a_address = 32'h8000_0200;
      void'(push_model(3'd4, 4'd6, 1'b0, 32'h8000_0200));
      @(posedge clk);
      #1 a_valid = 0;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!d_valid && guard < 40);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      checks++;
      if (d_valid !== 1'b0 || a_ready !== 1'b0 || count !== 16'd0 || d_data !== 64'd0 ||
          d_opcode !== 3'd0 || d_size !== 4'd0 || d_error !== 1'b0) begin
         errors++;
         $display("FAIL reset_abort: d_valid=%0b a_ready=%0b count=%0d data=%h op=%0d size=%0d err=%0b, required all 0",
                  d_valid, a_ready, count, d_data, d_opcode, d_size, d_error);
      end
      sb.delete();
      exp_resp = 16'd0;
      @(posedge clk);
      #1;
      checks++;
      if (d_valid !== 1'b0 || a_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_held: d_valid=%0b a_ready=%0b, required 0 0", d_valid, a_ready);
      end
      @(negedge clk);
      #2 rst_n = 1;
      @(posedge clk);
      #1;
      checks++;
      if (a_ready !== 1'b1 || d_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: a_ready=%0b d_valid=%0b, required 1 0", a_ready, d_valid);
      end
      repeat (5) @(negedge clk);
      run_txn(3'd4, 4'd3, 1'b1, 32'h8000_0018, 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
